// File: rtl/bcd_disp_pkg.sv
// Shared constants for the four-digit BCD seven-segment scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_disp_pkg;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [1:0] DIG_ONES      = 2'd0;
    localparam logic [1:0] DIG_TENS      = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS  = 2'd2;
    localparam logic [1:0] DIG_THOUSANDS = 2'd3;
endpackage

// File: rtl/seg7_decode.sv
// BCD code to active-low seven-segment pattern; codes above 9 show a dash.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (code_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end
endmodule

// File: rtl/bcd_display_scan.sv
// Latches four BCD digits and scans them onto a common-anode display
// with optional leading-zero blanking and registered active-low outputs.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] thousands,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic [3:0] dp_mask,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [3:0][3:0]  dig_q, dig_d;
    logic [3:0]       dpm_q, dpm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    logic             wrap;
    logic             blank_cur;
    logic [6:0]       seg_dec;

    assign wrap = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        dig_d = dig_q;
        dpm_d = dpm_q;
        if (load) begin
            dig_d = {thousands, hundreds, tens, ones};
            dpm_d = dp_mask;
        end
    end

    // Invalid codes are nonzero, so they stop blanking of lower digits.
    always_comb begin
        blank_cur = 1'b0;
        unique case (idx_q)
            DIG_ONES:      blank_cur = 1'b0;
            DIG_TENS:      blank_cur = blank_lz && dig_q[3] == 4'd0 &&
                                       dig_q[2] == 4'd0 && dig_q[1] == 4'd0;
            DIG_HUNDREDS:  blank_cur = blank_lz && dig_q[3] == 4'd0 &&
                                       dig_q[2] == 4'd0;
            DIG_THOUSANDS: blank_cur = blank_lz && dig_q[3] == 4'd0;
            default:       blank_cur = 1'b0;
        endcase
    end

    seg7_decode u_dec (
        .code_i  (dig_q[idx_q]),
        .blank_i (blank_cur),
        .seg_o   (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q <= '0;
            dpm_q <= '0;
            cnt_q <= '0;
            idx_q <= DIG_ONES;
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            dig_q <= dig_d;
            dpm_q <= dpm_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= seg_dec;
            dp_q  <= ~dpm_q[idx_q];
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized self-checking bench for bcd_display_scan against a
// cycle-count based reference model.
module tb_bcd_display_scan;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] thousands = '0, hundreds = '0, tens = '0, ones = '0;
    logic [3:0] dp_mask = '0;
    logic       blank_lz = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    bcd_display_scan #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .load(load),
        .thousands(thousands), .hundreds(hundreds),
        .tens(tens), .ones(ones), .dp_mask(dp_mask),
        .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    // Model: n counts non-reset edges since reset; displayed digit = (n/DIV)%4.
    logic [15:0] m_dig = '0;
    logic [3:0]  m_dpm = '0;
    int          n = 0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;

    function automatic logic [6:0] ref_seg(input logic [15:0] d,
                                           input int idx,
                                           input logic blz);
        logic [6:0] tab [10];
        int         upper;
        logic [3:0] code;
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        upper = 0;
        for (int j = idx; j < 4; j++) upper += int'(d[j*4 +: 4]);
        if (blz && idx != 0 && upper == 0) return 7'h7F;
        code = d[idx*4 +: 4];
        if (code > 4'd9) return 7'h3F;
        return tab[code];
    endfunction

    always @(posedge clk) begin
        int idx;
        if (rst) begin
            m_dig   <= '0;
            m_dpm   <= '0;
            n       <= 0;
            exp_an  <= 4'hF;
            exp_seg <= 7'h7F;
            exp_dp  <= 1'b1;
        end else begin
            idx = (n / DIV) % 4;
            exp_an  <= ~(4'b0001 << idx);
            exp_seg <= ref_seg(m_dig, idx, blank_lz);
            exp_dp  <= ~m_dpm[idx];
            n       <= n + 1;
            if (load) begin
                m_dig <= {thousands, hundreds, tens, ones};
                m_dpm <= dp_mask;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
                errors++;
                $display("FAIL reset_hold got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1",
                         an, seg, dp);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== 7'h40) begin
            errors++;
            $display("FAIL reset_release got an=%b seg=%h want an=1110 seg=40", an, seg);
        end
    endtask

    task automatic load_digits(input logic [3:0] t, h, e, o, m);
        thousands = t; hundreds = h; tens = e; ones = o; dp_mask = m;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_scan();
        int hits = 0;
        blank_lz = 1'b0;
        load_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'h0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL scan got %b/%h/%b want %b/%h/%b",
                         an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (an == 4'b0111 && seg == 7'h79) hits++;
        end
        checks++;
        if (hits != DIV) begin
            errors++;
            $display("FAIL scan_thousands_cycles got %0d want %0d", hits, DIV);
        end
    endtask

    task automatic test_blank();
        int dark = 0;
        blank_lz = 1'b1;
        load_digits(4'd0, 4'd0, 4'd4, 4'd2, 4'h0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL blank_042 got %b/%h/%b want %b/%h/%b",
                         an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if ((an == 4'b0111 || an == 4'b1011) && seg == 7'h7F) dark++;
        end
        checks++;
        if (dark != 2 * DIV) begin
            errors++;
            $display("FAIL blank_upper_dark got %0d want %0d", dark, 2 * DIV);
        end
        load_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'h0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL blank_zero got %b/%h/%b want %b/%h/%b",
                         an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_dash_dp();
        blank_lz = 1'b0;
        load_digits(4'd0, 4'd0, 4'd0, 4'hC, 4'b0001);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL dash_dp got %b/%h/%b want %b/%h/%b",
                         an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (an == 4'b1110 && (seg !== 7'h3F || dp !== 1'b0)) begin
                errors++;
                $display("FAIL dash_ones got seg=%h dp=%b want seg=3f dp=0", seg, dp);
            end
        end
    endtask

    task automatic test_wrap_load();
        int guard = 0;
        while (n % DIV != DIV - 1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++;
            $display("FAIL wrap_align got n=%0d want wrap within 20 cycles", n);
        end
        load_digits($urandom_range(1, 9), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15),
                    4'($urandom));
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL wrap_load got %b/%h/%b want %b/%h/%b",
                         an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        load_digits(4'd7, 4'd8, 4'd9, 4'd5, 4'hF);
        while (an !== 4'b1011 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 40) begin
            errors++;
            $display("FAIL reset_mid_align got an=%b want 1011", an);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid got %b/%h/%b want 1111/7f/1", an, seg, dp);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== {4'b1110, 7'h40, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_restart got %b/%h/%b want 1110/40/1", an, seg, dp);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load      = ($urandom_range(0, 3) == 0);
            thousands = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom);
            hundreds  = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom);
            tens      = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom);
            ones      = 4'($urandom);
            dp_mask   = 4'($urandom);
            blank_lz  = 1'($urandom);
            rst       = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL random[%0d] got %b/%h/%b want %b/%h/%b",
                         i, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
        rst  = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank();
        test_dash_dp();
        test_wrap_load();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
